// File: rtl/cella_array_model_if.sv
// Command/result bus for the CELLA array responder.
// The master drives commands and observes results; the slave is the array.
interface cella_array_model_if;
  logic [1:0]  op_code;
  logic [8:0]  addr;
  logic [15:0] data_bank;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        out_valid;
  logic [1:0]  out_op;
  logic [4:0]  match_cnt;
  logic        err;

  modport master (
    output op_code, addr, data_bank, data_in,
    input  data_out, out_valid, out_op, match_cnt, err
  );

  modport slave (
    input  op_code, addr, data_bank, data_in,
    output data_out, out_valid, out_op, match_cnt, err
  );
endinterface

// File: rtl/cella_array_model.sv
// CELLA 16x4x8 bit array: write, masked-invert read and column search, two-stage pipeline.
// Define CELLA_SEARCH_EN to build the column search; otherwise opcode 10 is rejected.
module cella_array_model #(
  parameter int BANKS = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 8
) (
  input logic               clk,
  input logic               rst,
  cella_array_model_if.slave bus
);

  logic [COLS-1:0] mem_q [BANKS][ROWS];
  logic [COLS-1:0] mem_d [BANKS][ROWS];

  logic [1:0]  op_p1_q,   op_p1_d;
  logic [8:0]  addr_p1_q, addr_p1_d;
  logic [15:0] bank_p1_q, bank_p1_d;
  logic        en_p1_q,   en_p1_d;
  logic        vld_p1_q,  vld_p1_d;

  logic [15:0] dout_p2_q, dout_p2_d;
  logic [1:0]  op_p2_q,   op_p2_d;
  logic [4:0]  cnt_p2_q,  cnt_p2_d;
  logic        err_p2_q,  err_p2_d;
  logic        vld_p2_q,  vld_p2_d;

  logic [3:0]      sel_bank;
  logic [1:0]      sel_row;
  logic [COLS-1:0] rd_word;
  logic [BANKS-1:0] match_vec;

  logic unused_ok;
  assign unused_ok = ^{bus.data_in[15:1], addr_p1_q[3:2]};

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  always_comb begin
    // S1: capture the command as presented on the bus
    op_p1_d   = bus.op_code;
    addr_p1_d = bus.addr;
    bank_p1_d = bus.data_bank;
    en_p1_d   = bus.data_in[0];
    vld_p1_d  = (bus.op_code != 2'b11);

    // S2: execute; an idle slot holds the previous result fields
    mem_d     = mem_q;
    dout_p2_d = dout_p2_q;
    op_p2_d   = op_p2_q;
    cnt_p2_d  = cnt_p2_q;
    err_p2_d  = err_p2_q;
    vld_p2_d  = 1'b0;
    sel_bank  = addr_p1_q[7:4];
    sel_row   = addr_p1_q[1:0];
    rd_word   = mem_q[sel_bank][sel_row] ^ {COLS{bank_p1_q[sel_bank]}};
    match_vec = '0;
`ifdef CELLA_SEARCH_EN
    for (int b = 0; b < BANKS; b++) begin
      match_vec[b] = ({mem_q[b][3][addr_p1_q[2:0]], mem_q[b][2][addr_p1_q[2:0]],
                       mem_q[b][1][addr_p1_q[2:0]], mem_q[b][0][addr_p1_q[2:0]]}
                      == bank_p1_q[3:0]);
    end
`endif

    if (vld_p1_q) begin
      vld_p2_d  = 1'b1;
      op_p2_d   = op_p1_q;
      err_p2_d  = 1'b0;
      dout_p2_d = '0;
      cnt_p2_d  = '0;
      if (addr_p1_q[8]) begin
        err_p2_d = 1'b1;
      end else begin
        case (op_p1_q)
          2'b01: mem_d[sel_bank][sel_row] = bank_p1_q[COLS-1:0];
          2'b00: if (en_p1_q) dout_p2_d = {8'h00, rd_word};
          2'b10: begin
`ifdef CELLA_SEARCH_EN
            if (en_p1_q) begin
              dout_p2_d = match_vec;
              cnt_p2_d  = popcnt16(match_vec);
            end
`else
            err_p2_d = 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++)
        for (int r = 0; r < ROWS; r++)
          mem_q[b][r] <= '0;
      op_p1_q   <= '0;
      addr_p1_q <= '0;
      bank_p1_q <= '0;
      en_p1_q   <= 1'b0;
      vld_p1_q  <= 1'b0;
      dout_p2_q <= '0;
      op_p2_q   <= 2'b11;
      cnt_p2_q  <= '0;
      err_p2_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      op_p1_q   <= op_p1_d;
      addr_p1_q <= addr_p1_d;
      bank_p1_q <= bank_p1_d;
      en_p1_q   <= en_p1_d;
      vld_p1_q  <= vld_p1_d;
      dout_p2_q <= dout_p2_d;
      op_p2_q   <= op_p2_d;
      cnt_p2_q  <= cnt_p2_d;
      err_p2_q  <= err_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign bus.data_out  = dout_p2_q;
  assign bus.out_valid = vld_p2_q;
  assign bus.out_op    = op_p2_q;
  assign bus.match_cnt = cnt_p2_q;
  assign bus.err       = err_p2_q;

endmodule

// File: tb/tb_cella_array_model.sv
// Randomized and directed bench for cella_array_model against a behavioural array model.
module tb_cella_array_model;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cella_array_model_if bus ();
  cella_array_model dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  logic [7:0]  mdl_mem [16][4];
  logic [1:0]  pend_op;
  logic [8:0]  pend_addr;
  logic [15:0] pend_db;
  logic        pend_en;
  logic        e_vld, e_err;
  logic [1:0]  e_op;
  logic [15:0] e_dout;
  logic [4:0]  e_cnt;

  task automatic mdl_reset();
    for (int b = 0; b < 16; b++)
      for (int r = 0; r < 4; r++) mdl_mem[b][r] = 8'h00;
    pend_op = 2'b11; pend_addr = '0; pend_db = '0; pend_en = 1'b0;
    e_vld = 1'b0; e_err = 1'b0; e_op = 2'b11; e_dout = '0; e_cnt = '0;
  endtask

  task automatic mdl_exec();
    int b, r, c;
    logic [7:0] w;
    logic [3:0] nib;
    if (pend_op == 2'b11) begin
      e_vld = 1'b0;
      return;
    end
    e_vld = 1'b1; e_op = pend_op; e_err = 1'b0; e_dout = '0; e_cnt = '0;
    b = int'(pend_addr[7:4]);
    r = int'(pend_addr[1:0]);
    c = int'(pend_addr[2:0]);
    if (pend_addr[8]) begin
      e_err = 1'b1;
    end else if (pend_op == 2'b01) begin
      mdl_mem[b][r] = pend_db[7:0];
    end else if (pend_op == 2'b00) begin
      w = mdl_mem[b][r];
      if (pend_db[b]) w = ~w;
      if (pend_en) e_dout = {8'h00, w};
    end else begin
`ifdef CELLA_SEARCH_EN
      if (pend_en) begin
        for (int k = 0; k < 16; k++) begin
          for (int rr = 0; rr < 4; rr++) nib[rr] = mdl_mem[k][rr][c];
          if (nib == pend_db[3:0]) e_dout[k] = 1'b1;
        end
        e_cnt = 5'($countones(e_dout));
      end
`else
      e_err = 1'b1;
`endif
    end
  endtask

  task automatic step(input logic [1:0] op, input logic [8:0] a,
                      input logic [15:0] db, input logic [15:0] di);
    @(negedge clk);
    bus.op_code = op; bus.addr = a; bus.data_bank = db; bus.data_in = di;
    @(posedge clk);
    #1;
    mdl_exec();
    pend_op = op; pend_addr = a; pend_db = db; pend_en = di[0];
    chk("out_valid", bus.out_valid, e_vld);
    chk("data_out",  bus.data_out,  e_dout);
    chk("out_op",    bus.out_op,    e_op);
    chk("match_cnt", bus.match_cnt, e_cnt);
    chk("err",       bus.err,       e_err);
  endtask

  task automatic nop();
    step(2'b11, 9'h000, 16'h0000, 16'h0000);
  endtask

  // Asynchronous reset asserted mid-cycle; inputs parked at NOP before release
  task automatic do_reset();
    #1 rst = 1'b1;
    bus.op_code = 2'b11;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_op",    bus.out_op,    2'b11);
    chk("rst_data_out",  bus.data_out,  16'h0000);
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [8:0]  a;
    logic [15:0] db;
    logic [7:0]  wd;

    rst = 1'b1;
    bus.op_code = 2'b11; bus.addr = '0; bus.data_bank = '0; bus.data_in = '0;
    mdl_reset();
    #12;
    chk("init_out_valid", bus.out_valid, 1'b0);
    chk("init_out_op",    bus.out_op,    2'b11);
    chk("init_match_cnt", bus.match_cnt, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream during writes
    step(2'b01, 9'h000, 16'h005A, 16'h0);
    step(2'b01, 9'h011, 16'h00C3, 16'h0);
    do_reset();
    step(2'b00, 9'h000, 16'h0000, 16'h1);
    nop();
    chk("rst_read_b0r0", bus.data_out, 16'h0000);

    // Write then read
    step(2'b01, 9'h000, 16'h00FF, 16'h0);
    step(2'b00, 9'h000, 16'h0000, 16'h1);
    nop();
    chk("raw_read", bus.data_out, 16'h00FF);
    step(2'b00, 9'h000, 16'h0000, 16'h1);
    nop();
    chk("read_nomask", bus.data_out, 16'h00FF);
    step(2'b00, 9'h000, 16'h0001, 16'h1);
    nop();
    chk("read_mask_b0", bus.data_out, 16'h0000);
    step(2'b00, 9'h000, 16'h0000, 16'h0);
    nop();
    chk("read_en0", bus.data_out, 16'h0000);

    // Boundary bank 15 row 3
    step(2'b01, 9'h0F3, 16'h00AA, 16'h0);
    step(2'b00, 9'h0F3, 16'h0000, 16'h1);
    nop();
    chk("read_b15r3", bus.data_out, 16'h00AA);
    step(2'b00, 9'h0F3, 16'h8000, 16'h1);
    nop();
    chk("read_b15r3_mask", bus.data_out, 16'h0055);

    // Rejected write, then confirm memory untouched
    step(2'b01, 9'h1FF, 16'h0012, 16'h1);
    nop();
    chk("err_write_err", bus.err, 1'b1);
    chk("err_write_vld", bus.out_valid, 1'b1);
    step(2'b00, 9'h0F3, 16'h0000, 16'h1);
    nop();
    chk("err_mem_kept", bus.data_out, 16'h00AA);

    // NOP yields no valid output
    nop();
    nop();
    chk("nop_vld", bus.out_valid, 1'b0);

`ifdef CELLA_SEARCH_EN
    do_reset();
    step(2'b01, 9'h003, 16'h00FF, 16'h0);
    step(2'b10, 9'h000, 16'h0000, 16'h1);
    nop();
    chk("srch_q0", bus.data_out, 16'hFFFE);
    chk("srch_q0_cnt", bus.match_cnt, 5'd15);
    step(2'b10, 9'h000, 16'h0008, 16'h1);
    nop();
    chk("srch_q8", bus.data_out, 16'h0001);
    chk("srch_q8_cnt", bus.match_cnt, 5'd1);
    step(2'b10, 9'h000, 16'hFF00, 16'h1);
    nop();
    chk("srch_hi_ign", bus.data_out, 16'hFFFE);
    step(2'b10, 9'h000, 16'h0000, 16'h0);
    nop();
    chk("srch_en0", bus.data_out, 16'h0000);
    chk("srch_en0_cnt", bus.match_cnt, 5'd0);
`else
    step(2'b10, 9'h000, 16'h0000, 16'h1);
    nop();
    chk("nosrch_vld", bus.out_valid, 1'b1);
    chk("nosrch_err", bus.err, 1'b1);
    chk("nosrch_dout", bus.data_out, 16'h0000);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 9'($urandom);
      a[8] = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: wd = 8'h00;
        1: wd = 8'hFF;
        default: wd = 8'($urandom);
      endcase
      db = 16'($urandom);
      if (op == 2'b01) db[7:0] = wd;
      if (op == 2'b10 && $urandom_range(0, 1) == 1) db[3:0] = 4'($urandom_range(0, 1) * 15);
      step(op, a, db, 16'($urandom_range(0, 3)));
      if (i == 200) do_reset();
    end
    nop();
    nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cella_array_model.md
# cella_array_model

Synthesizable responder for the CELLA compute-in-memory array command interface. It accepts the `op_code`/`addr`/`data_bank`/`data_in` bus that the array stimulus and controllers drive. It holds a 16-bank × 4-row × 8-column bit array and executes write, masked-invert read and column search. Results are returned through a registered two-stage pipeline. It is the array-side endpoint used in system simulation and as the FPGA stand-in for the macro.

## Interface
- `BANKS`, 16, number of banks; fixed, used for mask and match widths.
- `ROWS`, 4, rows per bank; also the search query width.
- `COLS`, 8, columns per row; also the read word width.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `op_code` input 2: 00 read, 01 write, 10 search, 11 NOP.
- `addr` input 9: `[8]` must be 0; `[7:4]` bank; `[1:0]` row (read/write); `[2:0]` column (search).
- `data_bank` input 16: write data `[7:0]`; read invert mask (bit b = bank b); search query `[3:0]`.
- `data_in` input 16: bit 0 = output enable for read/search; `[15:1]` ignored.
- `data_out` output 16: read word (zero-extended) or search match vector.
- `out_valid` output 1: `data_out`/`out_op`/`match_cnt`/`err` valid this cycle.
- `out_op` output 2: opcode of the result being presented.
- `match_cnt` output 5: popcount of the search match vector, 0..16.
- `err` output 1: the presented command was rejected.

## Operation
- One clock, one reset (`clk`, `rst`: asynchronous, active-high). Under `rst`:
  - array bits, both pipeline stages and all outputs clear to 0;
  - `out_op` resets to 2'b11.
- A command is sampled on every rising edge; there is no handshake and no backpressure.
- Stage S1 registers `op_code`, `addr`, `data_bank` and `data_in[0]`, plus `valid1`. `valid1` = 1 unless `op_code` is 11.
- Stage S2 executes the command and registers the outputs.
- Write (01): `mem[bank][row] <= data_bank[7:0]`. Output: `data_out` = 0, `match_cnt` = 0.
- Read (00): `w = mem[bank][row] ^ {8{data_bank[bank]}}`. `data_out = en ? {8'h00, w} : 0`.
- Search (10):
  - per bank b, `m[b] = ({mem[b][3][c], mem[b][2][c], mem[b][1][c], mem[b][0][c]} == data_bank[3:0])`, where c = `addr[2:0]`;
  - `data_out = en ? m : 0`; `match_cnt = popcount(data_out)`;
  - `data_bank[15:4]` is ignored.
- NOP (11): no S2 activity. `out_valid` = 0; the other outputs hold their previous values.
- `addr[8]` = 1 on read, write or search:
  - nothing is executed and memory is unchanged;
  - `out_valid` = 1, `err` = 1, `data_out` = 0, `match_cnt` = 0.
- `err` = 0 for all accepted commands.

## Timing
- Latency is 2 cycles. A command sampled at edge N gives a result on the outputs after edge N+1, valid for one cycle.
- Throughput is one command per cycle.
- Writes commit to memory at edge N+1.
- Read-after-write (write at N, read at N+1): the read executes at edge N+2 and returns the new data. No forwarding is needed.
- Back-to-back writes to the same row: the later write wins.
- A held command (same inputs for k cycles) executes k times. This is idempotent for all opcodes.
- `rst` asserted mid-pipeline: in-flight commands are discarded, memory clears, and `out_valid` drops asynchronously.
- After `rst` deasserts, the first valid output comes 2 edges after the first sampled command.

## Configuration
- `CELLA_SEARCH_EN` defined: search is implemented as described above.
- `CELLA_SEARCH_EN` undefined:
  - the match and popcount logic is removed;
  - opcode 10 is treated as rejected: `out_valid` = 1, `err` = 1, `data_out` = 0, `match_cnt` = 0.
- Read, write and NOP behaviour is identical in both builds.

## Test plan
- Reset mid-stream: assert `rst` during a write sequence, then read bank 0 row 0 with `data_in` = 1 → `data_out` = 0x0000; `out_op` = 11 while in reset.
- Write then read:
  - write bank 0 row 0 = 0xFF, read with mask 0 → 0x00FF;
  - mask 0x0001 → 0x0000;
  - `data_in[0]` = 0 → 0x0000;
  - the read issued the cycle after the write returns 0x00FF.
- Boundary: write `addr` = 0x0F3 (bank 15, row 3) = 0xAA, read without mask → 0x00AA; mask 0x8000 → 0x0055.
- Search (`CELLA_SEARCH_EN` defined):
  - setup: write bank 0 row 3 = 0xFF, all other rows and banks 0;
  - col 0, query 0 → `data_out` = 0xFFFE, `match_cnt` = 15;
  - query 8 → 0x0001, `match_cnt` = 1;
  - query `data_bank` = 0xFF00 → behaves as query 0;
  - `data_in` = 0 → 0x0000, `match_cnt` = 0.
- Errors and NOP:
  - `addr` = 0x1FF write → `err` = 1, memory unchanged (verified by a later read);
  - `op_code` = 11 → `out_valid` = 0 two cycles later.
- Build without `CELLA_SEARCH_EN`: search command → `out_valid` = 1, `err` = 1, `data_out` = 0.
